// File: rtl/l1_dm_cache_pkg.sv
// Shared types and helpers for the direct-mapped L1 cache.
// Provides line_t, state_t, default geometry and the byte-merge helper.
package l1_cache_pkg;

  localparam int S_INDEX_DEF  = 3;
  localparam int S_OFFSET_DEF = 5;

  typedef logic [255:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  function automatic line_t merge_word(
    input line_t       line,
    input int          word,
    input logic [3:0]  be,
    input logic [31:0] wd
  );
    line_t r;
    r = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[word*32 + b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/l1_dm_cache_if.sv
// CPU-side (word) and memory-side (line) buses of the L1 cache.
// master drives requests, slave returns data and resp.
interface cmem_if;
  logic        cmem_read;
  logic        cmem_write;
  logic [3:0]  cmem_byte_enable;
  logic [31:0] cmem_address;
  logic [31:0] cmem_wdata;
  logic [31:0] cmem_rdata;
  logic        cmem_resp;

  modport master (
    output cmem_read, cmem_write, cmem_byte_enable,
    output cmem_address, cmem_wdata,
    input  cmem_rdata, cmem_resp
  );

  modport slave (
    input  cmem_read, cmem_write, cmem_byte_enable,
    input  cmem_address, cmem_wdata,
    output cmem_rdata, cmem_resp
  );
endinterface

interface pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_dm_cache_ctrl.sv
// Miss FSM, pmem handshake and hit/miss decode for l1_dm_cache.
// Optional counters under macro L1_CACHE_STATS_EN (else tied to 0).
module l1_cache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF,
  localparam int S_TAG   = 32 - S_INDEX - S_OFFSET,
  localparam int LW      = 32 - S_OFFSET
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_rd,
  input  logic               req_wr,
  input  logic [LW-1:0]      req_line,
  input  logic               line_valid,
  input  logic               line_dirty,
  input  logic [S_TAG-1:0]   line_tag,
  input  logic               pmem_resp,
  output logic               resp,
  output logic               wb_done,
  output logic               fill_done,
  output logic [S_INDEX-1:0] busy_idx,
  output logic [S_TAG-1:0]   busy_tag,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_address,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);

  state_t          state;
  logic [LW-1:0]   line_q;
  logic            req;
  logic            hit;
  logic            miss;
  logic [S_TAG-1:0] req_tag;

  assign req      = req_rd | req_wr;
  assign req_tag  = req_line[LW-1:S_INDEX];
  assign hit      = line_valid && (line_tag == req_tag);
  assign resp     = (state == IDLE) && req && hit;
  assign miss     = (state == IDLE) && req && !hit;
  assign wb_done  = (state == WRITEBACK) && pmem_resp;
  assign fill_done = (state == FILL) && pmem_resp;
  assign busy_idx = line_q[S_INDEX-1:0];
  assign busy_tag = line_q[LW-1:S_INDEX];

  // Miss line address is latched so a dropped request still
  // completes its pmem transaction against the original set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      line_q       <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss) begin
            line_q <= req_line;
            if (line_valid && line_dirty) begin
              state        <= WRITEBACK;
              pmem_write   <= 1'b1;
              pmem_address <= {line_tag, req_line[S_INDEX-1:0],
                               {S_OFFSET{1'b0}}};
            end else begin
              state        <= FILL;
              pmem_read    <= 1'b1;
              pmem_address <= {req_line, {S_OFFSET{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state        <= FILL;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {line_q, {S_OFFSET{1'b0}}};
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L1_CACHE_STATS_EN
  // Set by a fill; the hit that then completes the request
  // belongs to that miss and is not counted as a hit.
  logic after_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      after_fill <= 1'b0;
    end else begin
      if (miss) miss_count <= miss_count + 32'd1;
      if (resp && !after_fill) hit_count <= hit_count + 32'd1;
      if (fill_done) after_fill <= 1'b1;
      else if (state == IDLE && (resp || !req)) after_fill <= 1'b0;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: rtl/l1_dm_cache.sv
// Direct-mapped write-back write-allocate L1: flop arrays + datapath.
// Ports: clk, rst_n, cmem (slave), pmem (master), hit/miss counters.
module l1_dm_cache
  import l1_cache_pkg::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  cmem_if.slave       cmem,
  pmem_if.master      pmem,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int S_TAG = 32 - S_INDEX - S_OFFSET;
  localparam int SETS  = 2 ** S_INDEX;
  localparam int WW    = S_OFFSET - 2;

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [S_TAG-1:0]   tag_q  [SETS];
  line_t              data_q [SETS];

  logic [S_INDEX-1:0] idx;
  logic [S_INDEX-1:0] busy_idx;
  logic [S_TAG-1:0]   busy_tag;
  logic [WW-1:0]      word;
  logic               resp;
  logic               wb_done;
  logic               fill_done;
  logic               pm_wr;
  logic               unused_ok;

  assign idx  = cmem.cmem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign word = cmem.cmem_address[S_OFFSET-1:2];
  assign unused_ok = ^cmem.cmem_address[1:0];

  l1_cache_ctrl #(
    .S_INDEX  (S_INDEX),
    .S_OFFSET (S_OFFSET)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_rd       (cmem.cmem_read),
    .req_wr       (cmem.cmem_write),
    .req_line     (cmem.cmem_address[31:S_OFFSET]),
    .line_valid   (valid_q[idx]),
    .line_dirty   (dirty_q[idx]),
    .line_tag     (tag_q[idx]),
    .pmem_resp    (pmem.pmem_resp),
    .resp         (resp),
    .wb_done      (wb_done),
    .fill_done    (fill_done),
    .busy_idx     (busy_idx),
    .busy_tag     (busy_tag),
    .pmem_read    (pmem.pmem_read),
    .pmem_write   (pm_wr),
    .pmem_address (pmem.pmem_address),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  assign pmem.pmem_write = pm_wr;
  assign pmem.pmem_wdata = pm_wr ? data_q[busy_idx] : '0;
  assign cmem.cmem_resp  = resp;
  assign cmem.cmem_rdata =
    resp ? data_q[idx][int'(word)*32 +: 32] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_done) begin
        valid_q[busy_idx] <= 1'b1;
        dirty_q[busy_idx] <= 1'b0;
      end else if (wb_done) begin
        dirty_q[busy_idx] <= 1'b0;
      end
      if (resp && cmem.cmem_write) dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data are plain storage; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[busy_idx] <= pmem.pmem_rdata;
      tag_q[busy_idx]  <= busy_tag;
    end else if (resp && cmem.cmem_write) begin
      data_q[idx] <= merge_word(data_q[idx], int'(word),
                                cmem.cmem_byte_enable,
                                cmem.cmem_wdata);
    end
  end

endmodule

// File: tb/tb_l1_dm_cache.sv
// Randomized self-checking bench for l1_dm_cache.
// Reference: per-set cache model plus sparse line memory.
module tb_l1_dm_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  cmem_if cm();
  pmem_if pm();

  l1_dm_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmem       (cm),
    .pmem       (pm),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks = 0;
  int errors = 0;

  bit           mv   [8];
  bit           md   [8];
  logic [23:0]  mt   [8];
  logic [255:0] mdat [8];
  int unsigned  mhit;
  int unsigned  mmiss;
  logic [255:0] mem [int unsigned];

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_line(input int unsigned ln);
    logic [255:0] v;
    if (!mem.exists(ln)) begin
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      mem[ln] = v;
    end
    return mem[ln];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    mhit  = 0;
    mmiss = 0;
  endtask

  task automatic chk_counts(input string tag);
`ifdef L1_CACHE_STATS_EN
    chk({tag, "_hits"}, hit_count, mhit);
    chk({tag, "_misses"}, miss_count, mmiss);
`else
    chk({tag, "_hits"}, hit_count, 0);
    chk({tag, "_misses"}, miss_count, 0);
`endif
  endtask

  task automatic access(input bit wr,
                        input logic [31:0] addr,
                        input logic [3:0] be,
                        input logic [31:0] wd,
                        output logic [31:0] rd);
    int           set;
    int           wi;
    logic [23:0]  tg;
    bit           exp_hit;
    bit           exp_wb;
    int unsigned  fill_ln;
    int unsigned  wb_ln;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    logic [255:0] exp_line;
    bit           saw_wb;
    bit           saw_fill;
    bit           prev_wr;
    bit           prev_rd;
    bit           done;
    int           cyc;
    int           dly;
    set      = int'(addr[7:5]);
    wi       = int'(addr[4:2]);
    tg       = addr[31:8];
    exp_hit  = mv[set] && (mt[set] == tg);
    exp_wb   = !exp_hit && mv[set] && md[set];
    wb_addr  = {mt[set], 3'(set), 5'b0};
    wb_ln    = wb_addr >> 5;
    wb_line  = mdat[set];
    fill_ln  = addr >> 5;
    exp_line = exp_hit ? mdat[set] : mem_line(fill_ln);
    saw_wb   = 0;
    saw_fill = 0;
    prev_wr  = 0;
    prev_rd  = 0;
    done     = 0;
    cyc      = 0;
    dly      = 0;
    rd       = '0;
    @(negedge clk);
    cm.cmem_read        = !wr;
    cm.cmem_write       = wr;
    cm.cmem_address     = addr;
    cm.cmem_byte_enable = be;
    cm.cmem_wdata       = wd;
    while (!done && cyc < 60) begin
      #1;
      if (cm.cmem_resp) begin
        done = 1;
        rd = cm.cmem_rdata;
        chk("resp_first_cycle", cyc == 0, exp_hit);
        chk("pmem_quiet", {pm.pmem_read, pm.pmem_write}, 0);
        chk("wb_seen", saw_wb, exp_wb);
        chk("fill_seen", saw_fill, !exp_hit);
        if (!wr) chk("rdata", rd, exp_line[wi*32 +: 32]);
      end else begin
        chk("pmem_excl", pm.pmem_read & pm.pmem_write, 0);
        if (pm.pmem_write && !prev_wr) begin
          saw_wb = 1;
          chk("wb_expected", exp_wb, 1);
          chk("wb_addr", pm.pmem_address, wb_addr);
          chk("wb_data", pm.pmem_wdata, wb_line);
          dly = $urandom_range(0, 3);
        end
        if (pm.pmem_read && !prev_rd) begin
          saw_fill = 1;
          chk("fill_order", saw_wb, exp_wb);
          chk("fill_addr", pm.pmem_address, {addr[31:5], 5'b0});
          dly = $urandom_range(0, 3);
        end
        prev_wr = pm.pmem_write;
        prev_rd = pm.pmem_read;
        if (pm.pmem_read || pm.pmem_write) begin
          if (dly == 0) begin
            pm.pmem_resp = 1'b1;
            if (pm.pmem_read) pm.pmem_rdata = mem_line(fill_ln);
          end else begin
            dly--;
          end
        end
        @(negedge clk);
        pm.pmem_resp = 1'b0;
        cyc++;
      end
    end
    if (!done) chk("resp_timeout", 0, 1);
    if (!exp_hit) begin
      mmiss++;
      if (exp_wb) mem[wb_ln] = wb_line;
      mdat[set] = exp_line;
      mt[set]   = tg;
      mv[set]   = 1'b1;
      md[set]   = 1'b0;
    end else begin
      mhit++;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdat[set][wi*32 + b*8 +: 8] = wd[b*8 +: 8];
      md[set] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_counts("count");
  endtask

  task automatic idle();
    @(negedge clk);
    cm.cmem_read  = 1'b0;
    cm.cmem_write = 1'b0;
  endtask

  logic [255:0] l2;
  logic [31:0]  r;
  logic [31:0]  a;
  bit           seen;

  initial begin
    cm.cmem_read        = 1'b0;
    cm.cmem_write       = 1'b0;
    cm.cmem_byte_enable = 4'h0;
    cm.cmem_address     = '0;
    cm.cmem_wdata       = '0;
    pm.pmem_rdata       = '0;
    pm.pmem_resp        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_resp", cm.cmem_resp, 0);
    chk("rst_rdata", cm.cmem_rdata, 0);
    chk("rst_pread", pm.pmem_read, 0);
    chk("rst_pwrite", pm.pmem_write, 0);
    chk("rst_paddr", pm.pmem_address, 0);
    chk("rst_pwdata", pm.pmem_wdata, 0);
    chk_counts("rst");

    for (int i = 0; i < 8; i++) l2[i*32 +: 32] = $urandom;
    l2[31:0]  = 32'hDEADBEEF;
    l2[63:32] = 32'hAAAAAAAA;
    mem[2] = l2;
    access(0, 32'h40, 4'h0, 0, r);
    chk("dir_fill_rdata", r, 32'hDEADBEEF);
    access(0, 32'h40, 4'h0, 0, r);
    chk("dir_hit_rdata", r, 32'hDEADBEEF);
    access(1, 32'h44, 4'b0011, 32'h11223344, r);
    access(0, 32'h44, 4'h0, 0, r);
    chk("dir_merge", r, 32'hAAAA3344);
    access(0, 32'h140, 4'h0, 0, r);
    l2 = mem[2];
    chk("dir_wb_mem", l2[63:32], 32'hAAAA3344);

    // Reset while a fill is outstanding.
    @(negedge clk);
    cm.cmem_read    = 1'b1;
    cm.cmem_address = 32'h260;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (pm.pmem_read) seen = 1;
      else @(negedge clk);
    end
    chk("rf_fill_started", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("rf_pread_drop", pm.pmem_read, 0);
    chk("rf_pwrite_low", pm.pmem_write, 0);
    chk("rf_paddr_zero", pm.pmem_address, 0);
    cm.cmem_read = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_counts("rf_rst");
    access(0, 32'h40, 4'h0, 0, r);
    chk("rf_refill_miss", mmiss, 1);

    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) << 8) |
          ($urandom_range(0, 7) << 5) |
          ($urandom_range(0, 7) << 2);
      access($urandom_range(0, 1) == 1, a,
             4'($urandom_range(0, 15)), $urandom, r);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    #1;
    chk("end_pmem_idle", {pm.pmem_read, pm.pmem_write}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_dm_cache.md
Name: l1_dm_cache

Overview:
Direct-mapped, write-back, write-allocate L1 cache placed between one CPU memory port (cmem_*, 32-bit word) and physical memory (pmem_*, 256-bit line).
One instance serves each of the CPU's two ports (A instruction, B data) in the mp3 top.
The CPU holds a request until cmem_resp. The cache resolves misses with optional line writeback, then line fill.

Parameters:
S_INDEX, 3, set-index bits; sets = 2**S_INDEX (default 8).
S_OFFSET, 5, line-offset bits; line = 32 bytes = 256 bits (fixed for pmem width).
S_TAG, 32-S_INDEX-S_OFFSET, tag width (derived, localparam).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmem_read  in  1  CPU read request, held until cmem_resp.
cmem_write  in  1  CPU write request, held until cmem_resp; never asserted together with cmem_read.
cmem_byte_enable  in  4  byte mask for writes.
cmem_address  in  32  byte address; bits [1:0] ignored.
cmem_wdata  in  32  write data.
cmem_rdata  out  32  read data, valid while cmem_resp=1.
cmem_resp  out  1  one-cycle completion pulse.
pmem_read  out  1  line fill request, held until pmem_resp.
pmem_write  out  1  line writeback request, held until pmem_resp.
pmem_address  out  32  line address, bits [4:0]=0.
pmem_wdata  out  256  writeback line.
pmem_rdata  in  256  fill line, valid with pmem_resp.
pmem_resp  in  1  physical memory completion.
hit_count  out  32  hits (see Optional Feature).
miss_count  out  32  misses (see Optional Feature).

Behaviour:
- Address split: tag=[31:8], index=[7:5], word=[4:2] at defaults.
- Storage: per set valid, dirty, tag and 256-bit data, all flops. Reset clears valid and dirty. Data and tag are not reset.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, request with hit (valid && tag match):
  - cmem_resp=1 combinationally in the same cycle.
  - Read: cmem_rdata = data[index] word [word].
  - Write: the bytes selected by cmem_byte_enable are merged into the word at the clock edge, and dirty is set.
  - Hit latency is 1 cycle.
- IDLE, request with miss:
  - Dirty victim -> WRITEBACK.
  - Clean or invalid victim -> FILL.
  - cmem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_address={stored_tag,index,5'b0}, pmem_wdata=data[index].
  - On pmem_resp: clear dirty, go to FILL.
- FILL:
  - pmem_read=1, pmem_address={req_tag,index,5'b0}.
  - On pmem_resp: data<=pmem_rdata, tag<=req_tag, valid<=1, dirty<=0, go to IDLE.
  - The next cycle is a hit and completes the request; a write then sets dirty.
- pmem_read and pmem_write are never both high. pmem outputs are 0 in IDLE.
- Request dropped with no resp (protocol violation): FSM finishes the current pmem transaction, returns to IDLE, then idles.
- Reset values: all outputs 0 (cmem_rdata 0, pmem_wdata 0), state IDLE.
  - Reset mid-WRITEBACK or mid-FILL aborts immediately; pmem_read/pmem_write drop asynchronously.
  - All lines are invalid after reset, so no stale dirty line is written back.
- Hit/miss accounting:
  - A miss is counted once, on the IDLE->WRITEBACK or IDLE->FILL transition.
  - A hit is counted on each IDLE cycle with cmem_resp=1 that was not preceded by a miss for the same request.

Optional Feature:
Macro L1_CACHE_STATS_EN.
- Defined: hit_count and miss_count are 32-bit registers reset to 0 and incremented per the accounting rules; they wrap at 2**32.
- Undefined: both ports are tied to 32'd0 and no counter logic is synthesized.

Decomposition:
- Package l1_cache_pkg holds:
  - typedef line_t (logic [255:0]);
  - state enum state_t {IDLE, WRITEBACK, FILL};
  - localparams for default S_INDEX/S_OFFSET;
  - function for byte-enable merge of a 32-bit word into a line.
- Sub-module l1_cache_ctrl: the FSM, the pmem handshake and hit/miss decode. The top holds the arrays and datapath muxes.

Test Plan:
- Post-reset read 0x0000_0040, pmem returns line with word0=0xDEADBEEF -> pmem_read 1 until resp, address 0x40, no pmem_write; next cycle cmem_resp=1, rdata=0xDEADBEEF; miss_count=1.
- Repeat read 0x40 -> cmem_resp in the same cycle, no pmem activity; hit_count=1.
- Write 0x44, data 0x11223344, byte_enable 4'b0011 over line word1=0xAAAAAAAA -> read 0x44 returns 0xAAAA3344; line dirty.
- Read 0x0000_0140 (same index 2, new tag) -> pmem_write first with address 0x40 and the merged line, then pmem_read at 0x140, then resp.
- rst_n low during FILL -> pmem_read drops immediately. Read 0x40 after release -> a new fill is issued (miss).
- Build without L1_CACHE_STATS_EN, run a mixed hit/miss sequence -> hit_count=miss_count=0 throughout.
